// File: rtl/grslatch_pkg.sv
// Shared types for the gated RS latch: operation decode, output record and reset value.
// Pure declarations; no state, no latency, no flow control.
package grslatch_pkg;

    localparam int DELAY_MIN = 1;
    localparam int DELAY_MAX = 15;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'd0,
        OP_SET    = 2'd1,
        OP_RESET  = 2'd2,
        OP_FORBID = 2'd3
    } latch_op_t;

    typedef struct packed {
        logic q;
        logic ql;
        logic forbid;
        logic race;
    } latch_out_t;

    localparam latch_out_t LATCH_RST = '{q: 1'b0, ql: 1'b1, forbid: 1'b0, race: 1'b0};

    // A closed gate looks exactly like R=S=0 to the core.
    function automatic latch_op_t decode_op(input logic ena, input logic r, input logic s);
        latch_op_t op;
        op = OP_HOLD;
        if (ena) begin
            case ({r, s})
                2'b01:   op = OP_SET;
                2'b10:   op = OP_RESET;
                2'b11:   op = OP_FORBID;
                default: op = OP_HOLD;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/grslatch_if.sv
// Gate/set/reset inputs and latch status outputs of one gated RS latch.
// The driver of ENA/R/S uses master; the latch itself uses slave.
interface grslatch_if;
    logic ENA;
    logic R;
    logic S;
    logic Q;
    logic Q_L;
    logic FORBID;
    logic RACE;

    modport master (
        output ENA, R, S,
        input  Q, Q_L, FORBID, RACE
    );

    modport slave (
        input  ENA, R, S,
        output Q, Q_L, FORBID, RACE
    );
endinterface

// File: rtl/grslatch_delay.sv
// DELAY-deep shift register of latch output records, flushed to LATCH_RST by synchronous reset.
// Latency DELAY cycles from din to dout; no backpressure, advances every clock.
module grslatch_delay
    import grslatch_pkg::*;
#(
    parameter int DELAY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  latch_out_t din,
    output latch_out_t dout
);

    latch_out_t stage [DELAY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                stage[i] <= LATCH_RST;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DELAY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DELAY-1];

endmodule

// File: rtl/grslatch.sv
// Cycle model of a gated NOR-style RS latch with forbidden-state and race reporting.
// Outputs appear DELAY cycles after the sampling edge; no backpressure, inputs sampled every edge.
module grslatch
    import grslatch_pkg::*;
#(
    parameter int   DELAY  = 1,
    parameter logic RACE_Q = 1'b0
) (
    input  logic           CLK,
    input  logic           RST,
    grslatch_if.slave      io
);

    if (DELAY < DELAY_MIN || DELAY > DELAY_MAX) begin : g_bad_delay
        $error("grslatch: DELAY must be in 1..15");
    end

    latch_op_t  op;
    latch_out_t core;
    latch_out_t core_nxt;
    latch_out_t out_dly;

    assign op = decode_op(io.ENA, io.R, io.S);

    // Leaving R=S=1 without one side winning (both released, or gate closing)
    // is resolved to RACE_Q so the core never holds Q=Q_L=0 with the gate shut.
    always_comb begin
        core_nxt        = core;
        core_nxt.forbid = 1'b0;
        core_nxt.race   = 1'b0;
        unique case (op)
            OP_SET: begin
                core_nxt.q  = 1'b1;
                core_nxt.ql = 1'b0;
            end
            OP_RESET: begin
                core_nxt.q  = 1'b0;
                core_nxt.ql = 1'b1;
            end
            OP_FORBID: begin
                core_nxt.q      = 1'b0;
                core_nxt.ql     = 1'b0;
                core_nxt.forbid = 1'b1;
            end
            default: begin
                if (core.forbid) begin
                    core_nxt.q    = RACE_Q;
                    core_nxt.ql   = ~RACE_Q;
                    core_nxt.race = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            core <= LATCH_RST;
        end else begin
            core <= core_nxt;
        end
    end

    // The first delay stage captures the same value as the core register,
    // so DELAY=1 makes the new state visible right after the sampling edge.
    grslatch_delay #(
        .DELAY (DELAY)
    ) u_delay (
        .clk  (CLK),
        .rst  (RST),
        .din  (core_nxt),
        .dout (out_dly)
    );

    assign io.Q      = out_dly.q;
    assign io.Q_L    = out_dly.ql;
    assign io.FORBID = out_dly.forbid;
    assign io.RACE   = out_dly.race;

endmodule

// File: tb/tb_grslatch.sv
// Bench for grslatch: vector table, hand sequences for latency/reset/master-slave, random phase vs model.
module tb_grslatch;

    logic CLK;
    logic RST;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    grslatch_if if0 ();
    grslatch_if if1 ();
    grslatch_if if4 ();
    grslatch_if ifm ();
    grslatch_if ifs ();

    grslatch #(.DELAY(1), .RACE_Q(1'b0)) u0 (.CLK(CLK), .RST(RST), .io(if0));
    grslatch #(.DELAY(1), .RACE_Q(1'b1)) u1 (.CLK(CLK), .RST(RST), .io(if1));
    grslatch #(.DELAY(4), .RACE_Q(1'b0)) u4 (.CLK(CLK), .RST(RST), .io(if4));
    grslatch #(.DELAY(1), .RACE_Q(1'b0)) um (.CLK(CLK), .RST(RST), .io(ifm));
    grslatch #(.DELAY(1), .RACE_Q(1'b0)) us (.CLK(CLK), .RST(RST), .io(ifs));

    // Slave gated by the inverted gate, fed crosswise from the master.
    assign ifs.ENA = ~ifm.ENA;
    assign ifs.R   = ifm.Q;
    assign ifs.S   = ifm.Q_L;

    int checks   = 0;
    int failures = 0;

    // Reference model, per instance: 0=u0 1=u1 2=u4 3=master 4=slave.
    // Output history word is {q, ql, forbid, race}; newest entry at index 0.
    int         dly [5] = '{1, 1, 4, 1, 1};
    bit         rq  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bit         mq  [5];
    bit         mql [5];
    logic [3:0] hist [5][16];

    task automatic model_step(input int k, input bit rst, input bit ena, input bit r, input bit s);
        bit gr, gs, was_forbid, race;
        gr         = ena && r;
        gs         = ena && s;
        was_forbid = !mq[k] && !mql[k];
        race       = 1'b0;
        if (rst) begin
            mq[k] = 1'b0; mql[k] = 1'b1;
        end else if (gr && gs) begin
            mq[k] = 1'b0; mql[k] = 1'b0;
        end else if (was_forbid && !(gr ^ gs)) begin
            mq[k] = rq[k]; mql[k] = !rq[k]; race = 1'b1;
        end else if (gs) begin
            mq[k] = 1'b1; mql[k] = 1'b0;
        end else if (gr) begin
            mq[k] = 1'b0; mql[k] = 1'b1;
        end
        if (rst) begin
            for (int i = 0; i < 16; i++) hist[k][i] = 4'b0100;
        end else begin
            for (int i = 15; i > 0; i--) hist[k][i] = hist[k][i-1];
            hist[k][0] = {mq[k], mql[k], (!mq[k] && !mql[k]), race};
        end
    endtask

    function automatic logic [3:0] get_out(input int k);
        case (k)
            0:       return {if0.Q, if0.Q_L, if0.FORBID, if0.RACE};
            1:       return {if1.Q, if1.Q_L, if1.FORBID, if1.RACE};
            2:       return {if4.Q, if4.Q_L, if4.FORBID, if4.RACE};
            3:       return {ifm.Q, ifm.Q_L, ifm.FORBID, ifm.RACE};
            default: return {ifs.Q, ifs.Q_L, ifs.FORBID, ifs.RACE};
        endcase
    endfunction

    task automatic check_vec(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: q/ql/forbid/race got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: capture inputs, advance the model on the edge, compare all instances after it.
    task automatic tick();
        bit e [5];
        bit r [5];
        bit s [5];
        bit rr;
        logic [3:0] act;
        e[0] = if0.ENA; r[0] = if0.R; s[0] = if0.S;
        e[1] = if1.ENA; r[1] = if1.R; s[1] = if1.S;
        e[2] = if4.ENA; r[2] = if4.R; s[2] = if4.S;
        e[3] = ifm.ENA; r[3] = ifm.R; s[3] = ifm.S;
        e[4] = !ifm.ENA; r[4] = hist[3][0][3]; s[4] = hist[3][0][2];
        rr = RST;
        @(posedge CLK);
        for (int k = 0; k < 5; k++) model_step(k, rr, e[k], r[k], s[k]);
        #1;
        for (int k = 0; k < 5; k++) begin
            act = get_out(k);
            check_vec($sformatf("model_inst%0d", k), act, hist[k][dly[k]-1]);
            checks++;
            if (act[1] === 1'b0 && act[3] === act[2]) begin
                failures++;
                $display("FAIL complement_inst%0d: q/ql/forbid/race got %b, Q must equal ~Q_L when FORBID=0", k, act);
            end
        end
    endtask

    // {rst, ena, r, s} -> expected {q, ql, forbid, race} on u0 (DELAY=1, RACE_Q=0).
    logic [7:0] vt [21];
    // {gate, master R, master S} -> expected slave {q, ql, forbid, race}.
    logic [6:0] mst [8];

    initial begin
        for (int k = 0; k < 5; k++) begin
            mq[k] = 1'b0; mql[k] = 1'b1;
            for (int i = 0; i < 16; i++) hist[k][i] = 4'b0100;
        end
        RST = 1'b1;
        if0.ENA = 0; if0.R = 0; if0.S = 0;
        if1.ENA = 0; if1.R = 0; if1.S = 0;
        if4.ENA = 0; if4.R = 0; if4.S = 0;
        ifm.ENA = 1; ifm.R = 0; ifm.S = 0;

        vt[0]  = 8'b1101_0100; vt[1]  = 8'b1101_0100; // reset wins over SET
        vt[2]  = 8'b0101_1000; vt[3]  = 8'b0100_1000; // set, hold
        vt[4]  = 8'b0110_0100; vt[5]  = 8'b0001_0100; // reset, gate closed
        vt[6]  = 8'b0111_0010; vt[7]  = 8'b0100_0101; // forbid, simultaneous release
        vt[8]  = 8'b0100_0100; vt[9]  = 8'b0101_1000; // race gone, set
        vt[10] = 8'b0111_0010; vt[11] = 8'b0110_0100; // forbid, S released first
        vt[12] = 8'b0111_0010; vt[13] = 8'b0101_1000; // forbid, R released first
        vt[14] = 8'b0111_0010; vt[15] = 8'b0011_0101; // forbid, gate closes
        vt[16] = 8'b0011_0100; vt[17] = 8'b0111_0010;
        vt[18] = 8'b0111_0010; vt[19] = 8'b1111_0100; // reset out of forbid
        vt[20] = 8'b0100_0100;

        mst[0] = 7'b1_01_0100; mst[1] = 7'b0_01_0100;
        mst[2] = 7'b1_10_0100; mst[3] = 7'b1_10_0100;
        mst[4] = 7'b0_10_1000; mst[5] = 7'b0_01_1000;
        mst[6] = 7'b1_01_1000; mst[7] = 7'b0_01_0100;

        for (int i = 0; i < 21; i++) begin
            RST     = vt[i][7];
            if0.ENA = vt[i][6]; if0.R = vt[i][5]; if0.S = vt[i][4];
            if1.ENA = vt[i][6]; if1.R = vt[i][5]; if1.S = vt[i][4];
            tick();
            check_vec($sformatf("vec%0d", i), get_out(0), vt[i][3:0]);
        end

        // RACE_Q=1 resolution.
        if1.ENA = 1; if1.R = 1; if1.S = 1; tick(); check_vec("u1_forbid", get_out(1), 4'b0010);
        if1.R = 0; if1.S = 0;               tick(); check_vec("u1_race", get_out(1), 4'b1001);
        tick(); check_vec("u1_race_end", get_out(1), 4'b1000);

        // DELAY=4 latency of a single SET pulse.
        if4.ENA = 1; if4.S = 1; tick(); check_vec("lat_k0", get_out(2), 4'b0100);
        if4.ENA = 0; if4.S = 0; tick(); check_vec("lat_k1", get_out(2), 4'b0100);
        tick(); check_vec("lat_k2", get_out(2), 4'b0100);
        tick(); check_vec("lat_k3", get_out(2), 4'b1000);
        if4.ENA = 1; if4.R = 1; tick();
        if4.ENA = 0; if4.R = 0;
        repeat (4) tick();
        check_vec("lat_clear", get_out(2), 4'b0100);

        // Reset while a SET is in transit flushes it.
        if4.ENA = 1; if4.S = 1; tick();
        if4.ENA = 0; if4.S = 0; RST = 1; tick(); check_vec("rst_transit", get_out(2), 4'b0100);
        RST = 0;
        for (int j = 0; j < 4; j++) begin
            tick(); check_vec($sformatf("no_late_set%0d", j), get_out(2), 4'b0100);
        end

        // Reset while a RACE pulse is in transit flushes it.
        if4.ENA = 1; if4.R = 1; if4.S = 1; tick();
        if4.R = 0; if4.S = 0; tick();
        if4.ENA = 0; RST = 1; tick(); check_vec("rst_race_transit", get_out(2), 4'b0100);
        RST = 0;
        for (int j = 0; j < 4; j++) begin
            tick(); check_vec($sformatf("no_late_race%0d", j), get_out(2), 4'b0100);
        end

        // Master-slave: slave only moves on the gate-low half.
        for (int i = 0; i < 8; i++) begin
            ifm.ENA = mst[i][6]; ifm.R = mst[i][5]; ifm.S = mst[i][4];
            tick();
            check_vec($sformatf("ms_step%0d", i), get_out(4), mst[i][3:0]);
        end

        // Random phase; every tick compares all instances with the model.
        for (int n = 0; n < 400; n++) begin
            RST     = ($urandom_range(0, 39) == 0);
            if0.ENA = ($urandom_range(0, 3) != 0); if0.R = $urandom_range(0, 1); if0.S = $urandom_range(0, 1);
            if1.ENA = ($urandom_range(0, 3) != 0); if1.R = $urandom_range(0, 1); if1.S = $urandom_range(0, 1);
            if4.ENA = ($urandom_range(0, 3) != 0); if4.R = $urandom_range(0, 1); if4.S = $urandom_range(0, 1);
            ifm.ENA = $urandom_range(0, 1);        ifm.R = $urandom_range(0, 1); ifm.S = $urandom_range(0, 1);
            tick();
        end
        RST = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grslatch.md
Name: grslatch

Overview:
- Cycle-based model of a gated (enabled) RS latch: NOR-style set/reset core, active-high gate ENA, complementary outputs Q / Q_L.
- Building block for master-slave latch/flip-flop structures. In those structures, the master's Q/Q_L drive the slave's R/S, and the slave is gated by inverted clock.
- Adds programmable output propagation delay and forbidden-input / race status flags for verification visibility.

Parameters:
- DELAY, 1, output propagation delay in CLK cycles (range 1..15). Models gate delay in cycle units.
- RACE_Q, 0, value Q settles to when R=S=1 is released simultaneously while gated. Q_L settles to ~RACE_Q.

Ports:
- CLK  input  1  single system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- ENA  input  1  gate; 1 = latch transparent to R/S, 0 = hold.
- R  input  1  reset request (drives Q to 0).
- S  input  1  set request (drives Q to 1).
- Q  output  1  latch output.
- Q_L  output  1  complementary latch output.
- FORBID  output  1  high while the delayed core is in the forbidden state (R=S=1 gated).
- RACE  output  1  one-cycle pulse when the forbidden state is exited by simultaneous release of R and S.

Behaviour:
- Core state q_core, ql_core updated on every CLK rising edge from sampled ENA/R/S:
  - ENA=0: hold both.
  - ENA=1, R=0, S=0: hold.
  - ENA=1, R=0, S=1: q=1, ql=0 (SET).
  - ENA=1, R=1, S=0: q=0, ql=1 (RESET).
  - ENA=1, R=1, S=1: q=0, ql=0 (FORBIDDEN; NOR-latch behaviour, both outputs low).
- Exit from FORBIDDEN:
  - With ENA=1 and R,S both 0 on the same edge: q=RACE_Q, ql=~RACE_Q, and RACE asserts.
  - Via ENA=0 (gate closes while R=S=1): the same RACE_Q resolution and RACE pulse apply. The core never holds Q=Q_L=0 with the gate closed.
  - One of R/S released first: normal SET/RESET applies, no RACE.
- Core output passes through a DELAY-stage shift register; Q/Q_L/FORBID/RACE are the last stage.
  - Total latency from input sampling edge to output = DELAY cycles (DELAY=1: visible after the sampling edge).
- Q == ~Q_L at all times except when FORBID=1.
- Reset (RST=1 at edge):
  - Core and every delay stage are loaded with q=0, ql=1, FORBID=0, RACE=0.
  - Outputs after that edge: Q=0, Q_L=1, FORBID=0, RACE=0.
  - Reset has priority over ENA/R/S.
- Reset mid-operation, including from FORBIDDEN: no RACE pulse is generated; the pipeline is flushed on the same edge.
- Inputs sampled only at CLK edges; no combinational path from inputs to outputs.

Decomposition:
- Package grslatch_pkg:
  - 2-bit enum latch_op_t {OP_HOLD, OP_SET, OP_RESET, OP_FORBID}.
  - Struct latch_out_t {q, ql, forbid, race}.
  - Reset constant LATCH_RST = {0,1,0,0}.
  - Decode function (ENA,R,S) -> latch_op_t.
- Sub-module grslatch_delay: parameterised DELAY-deep shift register of latch_out_t with synchronous reset to LATCH_RST.
- grslatch contains the decode, core state, FORBIDDEN-exit/race logic, and one grslatch_delay instance.

Test Plan:
- Reset: RST=1 for 2 cycles with S=1, ENA=1 -> Q=0, Q_L=1, FORBID=0, RACE=0. After release with S=1 held, Q=1, Q_L=0 DELAY cycles later.
- Set/reset/hold, DELAY=1:
  - ENA=1,S=1,R=0 -> Q=1.
  - Then S=0 -> Q stays 1.
  - Then R=1 -> Q=0, Q_L=1.
  - Then ENA=0, S=1 -> Q stays 0.
- Forbidden and race, RACE_Q=0: ENA=1,R=S=1 -> Q=0, Q_L=0, FORBID=1. Then R=S=0 -> Q=0, Q_L=1, FORBID=0, RACE=1 for exactly one cycle. Repeat with RACE_Q=1 -> Q=1, Q_L=0.
- Staggered exit: R=S=1 then S=0 (R still 1) -> Q=0, Q_L=1, RACE=0.
- Latency: DELAY=4, single SET pulse at edge k -> Q rises after edge k+3. RST asserted during transit -> Q=0, Q_L=1 next cycle, no late pulse.
- Master-slave: two instances, master ENA=gate, slave ENA=~gate, master Q->slave R, master Q_L->slave S. Drive the stimulus and check the slave output reflects the expected transitions only when the gate toggles.
